// File: rtl/mem_access_pkg.sv
// mem_access_pkg: op encodings, FSM states and lane helpers for mem_access_unit
package mem_access_pkg;
  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_SW  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd4;
  localparam logic [2:0] OP_LH  = 3'd5;
  localparam logic [2:0] OP_LHU = 3'd6;
  localparam logic [2:0] OP_SH  = 3'd7;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;
  function automatic logic is_load(input logic [2:0] op);
    return !(op == OP_SW || op == OP_SB || op == OP_SH);
  endfunction
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    return (op == OP_LW || op == OP_SW) ? (a != 2'd0) :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? a[0] : 1'b0;
  endfunction
endpackage

// File: rtl/byte_lane_align.sv
// byte_lane_align: little-endian lane extract/extend for loads and lane insert for byte/half stores
module byte_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] merged
);
  logic [31:0] b_sh, h_sh, b_mask, h_mask;
  logic [BYTE_W-1:0] b;
  logic [HALF_W-1:0] h;
  always_comb begin
    b_sh   = word >> {addr, 3'b000};
    h_sh   = word >> {addr[1], 4'b0000};
    b      = b_sh[BYTE_W-1:0];
    h      = h_sh[HALF_W-1:0];
    b_mask = 32'h0000_00ff << {addr, 3'b000};
    h_mask = 32'h0000_ffff << {addr[1], 4'b0000};
    ldata  = op == OP_LB  ? {{24{b[7]}}, b} :
             op == OP_LBU ? {24'd0, b} :
             op == OP_LH  ? {{16{h[15]}}, h} :
             op == OP_LHU ? {16'd0, h} : word;
    merged = op == OP_SB ? (word & ~b_mask) | ({24'd0, wdata[7:0]} << {addr, 3'b000}) :
                           (word & ~h_mask) | ({16'd0, wdata[15:0]} << {addr[1], 4'b0000});
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit with read-modify-write for byte/half stores
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state, state_n;
  logic [2:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, res_q, ldata, merged;
  logic err_q, sub_st;
  byte_lane_align u_align (
    .op(op_q), .addr(addr_q[1:0]), .word(mem_rdata), .wdata(wdata_q),
    .ldata(ldata), .merged(merged)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= misaligned(req_op, req_addr[1:0]);
      end
      if (state == ACCESS) res_q <= sub_st ? merged : ldata;
    end
  end
  always_comb begin
    sub_st     = op_q == OP_SB || op_q == OP_SH;
    state_n    = state == IDLE     ? (req_valid ? (misaligned(req_op, req_addr[1:0]) ? RESP : ACCESS) : IDLE) :
                 state == ACCESS   ? (sub_st ? MERGE_WR : RESP) :
                 state == MERGE_WR ? RESP : IDLE;
    req_ready  = state == IDLE;
    resp_valid = state == RESP;
    resp_err   = state == RESP && err_q;
    resp_rdata = (state == RESP && !err_q && is_load(op_q)) ? res_q : '0;
    mem_adr    = (state == ACCESS || state == MERGE_WR) ? addr_q >> 2 : '0;
    mem_read   = state == ACCESS && op_q != OP_SW;
    mem_write  = (state == ACCESS && op_q == OP_SW) || state == MERGE_WR;
    mem_wdata  = (state == ACCESS && op_q == OP_SW) ? wdata_q : state == MERGE_WR ? res_q : '0;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed-vector self-checking bench with a behavioural word memory
module tb_mem_access_unit;
  import mem_access_pkg::*;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [2:0] req_op = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata, mem_adr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:63];
  int nvec = 0, nmis = 0;
  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem_read ? mem[mem_adr[5:0]] : 32'd0;
  always @(posedge clk) if (mem_write) mem[mem_adr[5:0]] <= mem_wdata;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_op = op; req_addr = a; req_wdata = wd; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
  endtask
  task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] exp);
    start(op, a, 32'd0);
    @(negedge clk);
    check({tag, "_rd"}, {30'd0, mem_read, mem_write}, 32'd2);
    check({tag, "_adr"}, mem_adr, a >> 2);
    check({tag, "_nrdy"}, {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, {30'd0, resp_valid, resp_err}, 32'd2);
    check({tag, "_data"}, resp_rdata, exp);
  endtask
  task automatic run_sw(input string tag, input logic [31:0] a, input logic [31:0] wd);
    start(OP_SW, a, wd);
    @(negedge clk);
    check({tag, "_wr"}, {30'd0, mem_read, mem_write}, 32'd1);
    check({tag, "_adr"}, mem_adr, a >> 2);
    check({tag, "_wdata"}, mem_wdata, wd);
    @(negedge clk);
    check({tag, "_vld"}, {30'd0, resp_valid, resp_err}, 32'd2);
    check({tag, "_data"}, resp_rdata, 32'd0);
  endtask
  task automatic run_rmw(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
    start(op, a, wd);
    @(negedge clk);
    check({tag, "_rd"}, {30'd0, mem_read, mem_write}, 32'd2);
    check({tag, "_resp_early"}, {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_wr"}, {30'd0, mem_read, mem_write}, 32'd1);
    check({tag, "_adr"}, mem_adr, a >> 2);
    check({tag, "_wdata"}, mem_wdata, exp);
    @(negedge clk);
    check({tag, "_vld"}, {30'd0, resp_valid, resp_err}, 32'd2);
    check({tag, "_data"}, resp_rdata, 32'd0);
    check({tag, "_mem"}, mem[a[7:2]], exp);
  endtask
  task automatic run_err(input string tag, input logic [2:0] op, input logic [31:0] a);
    start(op, a, 32'hffff_ffff);
    @(negedge clk);
    check({tag, "_vld"}, {30'd0, resp_valid, resp_err}, 32'd3);
    check({tag, "_data"}, resp_rdata, 32'd0);
    check({tag, "_strb"}, {30'd0, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    check({tag, "_after"}, {29'd0, resp_valid, mem_read, mem_write}, 32'd0);
  endtask
  initial begin
    int acc, resp, last;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[5] = 32'h8000_12f0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_strb", {29'd0, resp_valid, mem_read, mem_write}, 32'd0);
    check("rst_outs", resp_rdata | mem_adr | mem_wdata | {31'd0, resp_err}, 32'd0);
    rst = 0;
    run_load("lb14", OP_LB, 32'h14, 32'hffff_fff0);
    run_load("lbu14", OP_LBU, 32'h14, 32'h0000_00f0);
    run_load("lh16", OP_LH, 32'h16, 32'hffff_8000);
    run_load("lhu16", OP_LHU, 32'h16, 32'h0000_8000);
    run_load("lh14", OP_LH, 32'h14, 32'h0000_12f0);
    run_load("lb17", OP_LB, 32'h17, 32'hffff_ff80);
    run_load("lbu15", OP_LBU, 32'h15, 32'h0000_0012);
    mem[5] = 32'h1122_3344;
    run_rmw("sb17", OP_SB, 32'h17, 32'h0000_00ab, 32'hab22_3344);
    run_rmw("sh16", OP_SH, 32'h16, 32'hcccc_5566, 32'h5566_3344);
    run_rmw("sb14", OP_SB, 32'h14, 32'h0000_0099, 32'h5566_3399);
    run_sw("sw20", 32'h20, 32'hdead_beef);
    check("sw20_mem", mem[8], 32'hdead_beef);
    run_load("lw20", OP_LW, 32'h20, 32'hdead_beef);
    run_err("lw22", OP_LW, 32'h22);
    run_err("sh13", OP_SH, 32'h13);
    run_err("lhu15", OP_LHU, 32'h15);
    run_err("sw21", OP_SW, 32'h21);
    check("err_mem5", mem[5], 32'h5566_3399);
    acc = 0; resp = 0; last = -3;
    @(negedge clk);
    req_op = OP_LW; req_addr = 32'h20; req_valid = 1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) begin
        acc++;
        check("stream_gap", i - last, 32'd3);
        last = i;
      end
      if (resp_valid) begin
        resp++;
        check("stream_data", resp_rdata, 32'hdead_beef);
      end
    end
    @(negedge clk);
    req_valid = 0;
    check("stream_acc", acc, 32'd4);
    check("stream_resp", resp, 32'd4);
    start(OP_SH, 32'h16, 32'h0000_7777);
    @(negedge clk);
    check("abort_access", {30'd0, mem_read, mem_write}, 32'd2);
    #2 rst = 1;
    #1;
    check("abort_strb", {29'd0, resp_valid, mem_read, mem_write}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_adr", mem_adr, 32'd0);
    @(negedge clk);
    rst = 0;
    resp = 0;
    repeat (3) begin
      @(negedge clk);
      resp += int'(resp_valid) + int'(mem_write);
    end
    check("abort_noresp", resp, 32'd0);
    check("abort_mem5", mem[5], 32'h5566_3399);
    run_load("post_rst", OP_LHU, 32'h16, 32'h0000_5566);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
